vm_multi_ctrl: RTL and testbench
================================

Name: vm_multi_ctrl

Overview:
- Parametrised vending-machine controller: accepts coins, tracks balance, vends the selected item, decrements stock and returns change.
- Generalises the single-shot user/supplier machine to N item slots, a per-slot stock and cost table, configurable widths, and explicit restock/vend arbitration.
- Sits between the coin/button front panel and the dispenser/change actuators; the supplier port programs the table.

Parameters:
- NUM_ITEMS, 8, number of item slots (power of two, ≥2).
- COUNT_W, 4, stock counter width per slot.
- COST_W, 8, cost width per slot (cents).
- BAL_W, 16, balance register width (cents).
- ITEM_W, $clog2(NUM_ITEMS), slot index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- coins  in  2  coin code per cycle: 00 none, 01 = 5, 10 = 10, 11 = 25 cents.
- buttons  in  ITEM_W  slot index selected by the user.
- select  in  1  one-cycle vend request for slot `buttons`.
- item  in  ITEM_W  supplier slot index.
- count  in  COUNT_W  supplier stock to load.
- cost  in  COST_W  supplier cost to load.
- valid  in  1  supplier write strobe.
- product  out  ITEM_W  slot index being dispensed; meaningful only when status = VENDED.
- status  out  2  00 IDLE, 01 VENDED, 10 NOFUNDS, 11 SOLDOUT.
- balance  out  BAL_W  current credit.
- info  out  COST_W  cost of slot `buttons`, registered.
- change  out  BAL_W  change returned; valid for one cycle with status = VENDED.

Behaviour:
- Reset (sync): product = 0, status = IDLE, balance = 0, info = 0, change = 0; all stock and cost entries = 0; FSM → IDLE.
- FSM states:
  - IDLE: balance = 0.
  - CREDIT: balance > 0.
  - VEND: one cycle.
  - RESULT: one cycle.
- Coins: balance += coin value on the cycle after the coin is presented. Saturate at 2^BAL_W−1; excess is discarded. The first coin moves IDLE → CREDIT.
- Restock: valid in IDLE or CREDIT writes stock[item] = count and cost[item] = cost the next cycle. While in VEND or RESULT, valid is ignored; the supplier must hold it.
- Simultaneous valid and select in the same cycle: restock wins and select is dropped. A coin in that cycle is still accepted.
- Vend request: select in CREDIT or IDLE latches `buttons` and goes to VEND. Evaluation in VEND uses the updated stock and cost:
  - stock = 0 → status = SOLDOUT, balance unchanged.
  - balance < cost → status = NOFUNDS, balance unchanged.
  - otherwise → product = slot, status = VENDED, change = balance − cost, stock decrements by 1, balance = 0.
- Timing: status/product/change are visible in RESULT, 2 cycles after select. The next cycle returns to IDLE or CREDIT according to balance. Status holds its last value until the next vend evaluation.
- Cost = 0 slot with stock > 0 vends with change = full balance, including when balance = 0.
- Coins arriving in VEND or RESULT are still accumulated. On a VENDED outcome they add to the post-vend balance (0 + coin).
- select in VEND or RESULT is ignored.
- info updates every cycle as the registered cost[buttons].
- Reset mid-vend aborts with no dispense and clears the balance.

Optional Feature:
- Macro VM_REFUND_EN.
- When defined:
  - Adds input port `cancel` (1 bit).
  - cancel in CREDIT → change = balance, balance = 0, status = IDLE for one cycle, then IDLE state.
  - cancel together with select: cancel wins.
- When undefined: no port; credit persists until spent.

Decomposition:
- Package vm_multi_pkg holds:
  - status_e enum (IDLE, VENDED, NOFUNDS, SOLDOUT);
  - state_e FSM enum;
  - coin code constants and coin_value() function mapping 2-bit code to cents.
- Sub-module vm_item_table: NUM_ITEMS × (COUNT_W + COST_W) register file with
  - one write port (supplier), one decrement port (vend), two read ports (vend slot, info slot);
  - decrement and write to the same slot in the same cycle → write wins.

Test Plan:
- Reset, then restock slot 3 with count = 2, cost = 35; insert 25 and 25, then select slot 3 → 2 cycles later: status = VENDED, product = 3, change = 15, balance = 0, stock[3] = 1.
- Restock slot 5 with count = 0, cost = 10; insert 10, select slot 5 → status = SOLDOUT, balance = 10, no change pulse.
- Slot 1 cost = 50; insert 25, select slot 1 → status = NOFUNDS, balance = 25; insert 25, select again → VENDED, change = 0.
- With BAL_W = 6, insert 25 three times → balance saturates at 63.
- Assert valid (slot 2, count 9, cost 20) in the same cycle as select for slot 2 → restock applied, no vend; info = 20 when buttons = 2.
- With VM_REFUND_EN: insert 10 and 5, assert cancel → change = 15 for one cycle, balance = 0, state IDLE.

Source files
------------

// File: rtl/vm_multi_pkg.sv
// Shared types, coin encoding and coin valuation for the multi-slot vending controller.
package vm_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_VENDED  = 2'b01,
    ST_NOFUNDS = 2'b10,
    ST_SOLDOUT = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CREDIT = 2'b01,
    S_VEND   = 2'b10,
    S_RESULT = 2'b11
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  function automatic logic [4:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  coin_value = 5'd5;
      COIN_10: coin_value = 5'd10;
      COIN_25: coin_value = 5'd25;
      default: coin_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm_item_table.sv
// Per-slot stock/cost register file: one supplier write port, one vend decrement
// port, two read ports. A write to the slot being decremented takes priority.
module vm_item_table #(
  parameter int NUM_ITEMS = 8,
  parameter int COUNT_W   = 4,
  parameter int COST_W    = 8,
  parameter int ITEM_W    = $clog2(NUM_ITEMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ITEM_W-1:0]  waddr,
  input  logic [COUNT_W-1:0] wcount,
  input  logic [COST_W-1:0]  wcost,
  input  logic               dec,
  input  logic [ITEM_W-1:0]  daddr,
  input  logic [ITEM_W-1:0]  raddr_a,
  output logic [COUNT_W-1:0] count_a,
  output logic [COST_W-1:0]  cost_a,
  input  logic [ITEM_W-1:0]  raddr_b,
  output logic [COST_W-1:0]  cost_b
);

  logic [COUNT_W-1:0] stock_q [NUM_ITEMS];
  logic [COST_W-1:0]  cost_q  [NUM_ITEMS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= '0;
        cost_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (we && waddr == ITEM_W'(i)) begin
          stock_q[i] <= wcount;
          cost_q[i]  <= wcost;
        end else if (dec && daddr == ITEM_W'(i) && stock_q[i] != '0) begin
          stock_q[i] <= stock_q[i] - COUNT_W'(1);
        end
      end
    end
  end

  assign count_a = stock_q[raddr_a];
  assign cost_a  = cost_q[raddr_a];
  assign cost_b  = cost_q[raddr_b];

endmodule

// File: rtl/vm_multi_ctrl.sv
// Multi-slot vending controller: coin credit, vend evaluation, restock arbitration.
// Optional refund/cancel input enabled by defining VM_REFUND_EN.
//
// state    | meaning
// S_IDLE   | no credit held
// S_CREDIT | credit held, accepting coins/select/restock
// S_VEND   | evaluate latched slot against stock and cost (one cycle)
// S_RESULT | outcome visible on status/product/change (one cycle)
module vm_multi_ctrl
  import vm_multi_pkg::*;
#(
  parameter int NUM_ITEMS = 8,
  parameter int COUNT_W   = 4,
  parameter int COST_W    = 8,
  parameter int BAL_W     = 16,
  parameter int ITEM_W    = $clog2(NUM_ITEMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         coins,
  input  logic [ITEM_W-1:0]  buttons,
  input  logic               select,
  input  logic [ITEM_W-1:0]  item,
  input  logic [COUNT_W-1:0] count,
  input  logic [COST_W-1:0]  cost,
  input  logic               valid,
`ifdef VM_REFUND_EN
  input  logic               cancel,
`endif
  output logic [ITEM_W-1:0]  product,
  output logic [1:0]         status,
  output logic [BAL_W-1:0]   balance,
  output logic [COST_W-1:0]  info,
  output logic [BAL_W-1:0]   change
);

  localparam int CMP_W = (BAL_W > COST_W) ? BAL_W : COST_W;

  state_e             state, state_nxt;
  status_e            status_q;
  logic [ITEM_W-1:0]  slot_q;
  logic [COUNT_W-1:0] vend_count;
  logic [COST_W-1:0]  vend_cost, info_cost;
  logic [BAL_W:0]     bal_sum;
  logic [BAL_W-1:0]   bal_coin;
  logic [CMP_W-1:0]   bal_x, cost_x;
  logic               restock, vend_req, refund, in_stock, afford, vend_ok;

  vm_item_table #(
    .NUM_ITEMS(NUM_ITEMS), .COUNT_W(COUNT_W), .COST_W(COST_W), .ITEM_W(ITEM_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (restock),
    .waddr   (item),
    .wcount  (count),
    .wcost   (cost),
    .dec     (vend_ok),
    .daddr   (slot_q),
    .raddr_a (slot_q),
    .count_a (vend_count),
    .cost_a  (vend_cost),
    .raddr_b (buttons),
    .cost_b  (info_cost)
  );

  // Saturating accumulate; excess over the register range is discarded.
  assign bal_sum  = {1'b0, balance} + (BAL_W+1)'(coin_value(coins));
  assign bal_coin = bal_sum[BAL_W] ? '1 : bal_sum[BAL_W-1:0];

  assign bal_x    = CMP_W'(balance);
  assign cost_x   = CMP_W'(vend_cost);
  assign in_stock = (vend_count != '0);
  assign afford   = (bal_x >= cost_x);
  assign vend_ok  = (state == S_VEND) && in_stock && afford;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restock   = 1'b0;
    vend_req  = 1'b0;
    refund    = 1'b0;
    case (state)
      S_IDLE, S_CREDIT: begin
        restock = valid;
`ifdef VM_REFUND_EN
        refund  = cancel && (state == S_CREDIT);
`endif
        vend_req = select && !valid && !refund;
        if (vend_req)    state_nxt = S_VEND;
        else if (refund) state_nxt = S_IDLE;
        else             state_nxt = (bal_coin != '0) ? S_CREDIT : S_IDLE;
      end
      S_VEND:  state_nxt = S_RESULT;
      default: state_nxt = (bal_coin != '0) ? S_CREDIT : S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= ST_IDLE;
      product  <= '0;
      balance  <= '0;
      info     <= '0;
      change   <= '0;
      slot_q   <= '0;
    end else begin
      info   <= info_cost;
      change <= '0;
      if (vend_req) slot_q <= buttons;
      if (refund) begin
        balance  <= '0;
        change   <= balance;
        status_q <= ST_IDLE;
      end else if (state == S_VEND) begin
        if (!in_stock) begin
          status_q <= ST_SOLDOUT;
          balance  <= bal_coin;
        end else if (!afford) begin
          status_q <= ST_NOFUNDS;
          balance  <= bal_coin;
        end else begin
          // Coins landing during the vend cycle start the fresh post-vend credit.
          status_q <= ST_VENDED;
          product  <= slot_q;
          change   <= BAL_W'(bal_x - cost_x);
          balance  <= BAL_W'(coin_value(coins));
        end
      end else begin
        balance <= bal_coin;
      end
    end
  end

  assign status = status_q;

endmodule

// File: tb/tb_vm_multi_ctrl.sv
// Directed self-checking bench for vm_multi_ctrl; exercises the refund path when VM_REFUND_EN is defined.
module tb_vm_multi_ctrl;

  logic        clk = 1'b0;
  logic        rst, select, valid, cancel;
  logic [1:0]  coins, coins6;
  logic [2:0]  buttons, item;
  logic [3:0]  count;
  logic [7:0]  cost;
  logic [2:0]  product, product6;
  logic [1:0]  status, status6;
  logic [15:0] balance, change;
  logic [7:0]  info, info6;
  logic [5:0]  balance6, change6;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vm_multi_ctrl dut (
    .clk(clk), .rst(rst), .coins(coins), .buttons(buttons), .select(select),
    .item(item), .count(count), .cost(cost), .valid(valid),
`ifdef VM_REFUND_EN
    .cancel(cancel),
`endif
    .product(product), .status(status), .balance(balance), .info(info), .change(change)
  );

  vm_multi_ctrl #(.BAL_W(6)) dut6 (
    .clk(clk), .rst(rst), .coins(coins6), .buttons(3'd0), .select(1'b0),
    .item(3'd0), .count(4'd0), .cost(8'd0), .valid(1'b0),
`ifdef VM_REFUND_EN
    .cancel(1'b0),
`endif
    .product(product6), .status(status6), .balance(balance6), .info(info6), .change(change6)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; coins = 2'b00; coins6 = 2'b00; buttons = '0; select = 1'b0;
    item = '0; count = '0; cost = '0; valid = 1'b0; cancel = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic coin(input logic [1:0] code);
    coins = code; cyc(); coins = 2'b00;
  endtask

  task automatic restock(input logic [2:0] s, input logic [3:0] n, input logic [7:0] c);
    item = s; count = n; cost = c; valid = 1'b1; cyc(); valid = 1'b0;
  endtask

  task automatic vend(input logic [2:0] s);
    buttons = s; select = 1'b1; cyc(); select = 1'b0; cyc();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (status !== 2'b00) begin fails++; $display("FAIL reset_status got %0d want 0", status); end
    tests++; if (balance !== 16'd0) begin fails++; $display("FAIL reset_balance got %0d want 0", balance); end
    tests++; if (change !== 16'd0) begin fails++; $display("FAIL reset_change got %0d want 0", change); end
    tests++; if (info !== 8'd0) begin fails++; $display("FAIL reset_info got %0d want 0", info); end
    tests++; if (product !== 3'd0) begin fails++; $display("FAIL reset_product got %0d want 0", product); end
  endtask

  task automatic test_vend_change();
    do_reset();
    restock(3'd3, 4'd2, 8'd35);
    coin(2'b11); coin(2'b11);
    tests++; if (balance !== 16'd50) begin fails++; $display("FAIL credit50 got %0d want 50", balance); end
    vend(3'd3);
    tests++; if (status !== 2'b01) begin fails++; $display("FAIL vend3_status got %0d want 1", status); end
    tests++; if (product !== 3'd3) begin fails++; $display("FAIL vend3_product got %0d want 3", product); end
    tests++; if (change !== 16'd15) begin fails++; $display("FAIL vend3_change got %0d want 15", change); end
    tests++; if (balance !== 16'd0) begin fails++; $display("FAIL vend3_balance got %0d want 0", balance); end
    cyc();
    tests++; if (change !== 16'd0) begin fails++; $display("FAIL change_pulse got %0d want 0", change); end
    tests++; if (info !== 8'd35) begin fails++; $display("FAIL info3 got %0d want 35", info); end
    coin(2'b11); coin(2'b11);
    vend(3'd3);
    tests++; if (change !== 16'd15) begin fails++; $display("FAIL vend3b_change got %0d want 15", change); end
    cyc();
    coin(2'b11);
    vend(3'd3);
    tests++; if (status !== 2'b11) begin fails++; $display("FAIL stock_exhausted got %0d want 3", status); end
    tests++; if (balance !== 16'd25) begin fails++; $display("FAIL soldout_bal got %0d want 25", balance); end
  endtask

  task automatic test_soldout();
    do_reset();
    restock(3'd5, 4'd0, 8'd10);
    coin(2'b10);
    vend(3'd5);
    tests++; if (status !== 2'b11) begin fails++; $display("FAIL soldout_status got %0d want 3", status); end
    tests++; if (balance !== 16'd10) begin fails++; $display("FAIL soldout_balance got %0d want 10", balance); end
    tests++; if (change !== 16'd0) begin fails++; $display("FAIL soldout_change got %0d want 0", change); end
  endtask

  task automatic test_nofunds();
    do_reset();
    restock(3'd1, 4'd3, 8'd50);
    coin(2'b11);
    vend(3'd1);
    tests++; if (status !== 2'b10) begin fails++; $display("FAIL nofunds_status got %0d want 2", status); end
    tests++; if (balance !== 16'd25) begin fails++; $display("FAIL nofunds_balance got %0d want 25", balance); end
    cyc();
    tests++; if (status !== 2'b10) begin fails++; $display("FAIL status_hold got %0d want 2", status); end
    coin(2'b11);
    vend(3'd1);
    tests++; if (status !== 2'b01) begin fails++; $display("FAIL exact_status got %0d want 1", status); end
    tests++; if (change !== 16'd0) begin fails++; $display("FAIL exact_change got %0d want 0", change); end
    tests++; if (product !== 3'd1) begin fails++; $display("FAIL exact_product got %0d want 1", product); end
  endtask

  task automatic test_saturate();
    do_reset();
    coins6 = 2'b11; cyc(); cyc();
    tests++; if (balance6 !== 6'd50) begin fails++; $display("FAIL sat_pre got %0d want 50", balance6); end
    cyc(); coins6 = 2'b00;
    tests++; if (balance6 !== 6'd63) begin fails++; $display("FAIL sat_63 got %0d want 63", balance6); end
  endtask

  task automatic test_restock_select();
    do_reset();
    buttons = 3'd2; select = 1'b1; valid = 1'b1; item = 3'd2; count = 4'd9; cost = 8'd20; coins = 2'b10;
    cyc();
    select = 1'b0; valid = 1'b0; coins = 2'b00;
    cyc();
    tests++; if (status !== 2'b00) begin fails++; $display("FAIL drop_select got %0d want 0", status); end
    tests++; if (balance !== 16'd10) begin fails++; $display("FAIL coin_kept got %0d want 10", balance); end
    tests++; if (info !== 8'd20) begin fails++; $display("FAIL info2 got %0d want 20", info); end
    coin(2'b10);
    vend(3'd2);
    tests++; if (status !== 2'b01 || change !== 16'd0) begin
      fails++; $display("FAIL vend2 got status %0d change %0d want 1 0", status, change);
    end
  endtask

  task automatic test_zero_cost_and_coin_in_vend();
    do_reset();
    restock(3'd4, 4'd1, 8'd0);
    vend(3'd4);
    tests++; if (status !== 2'b01 || product !== 3'd4) begin
      fails++; $display("FAIL free_vend got status %0d product %0d want 1 4", status, product);
    end
    cyc();
    restock(3'd6, 4'd5, 8'd10);
    coin(2'b11);
    buttons = 3'd6; select = 1'b1; cyc();
    select = 1'b0; coins = 2'b10; cyc(); coins = 2'b00;
    tests++; if (change !== 16'd15) begin fails++; $display("FAIL vend6_change got %0d want 15", change); end
    tests++; if (balance !== 16'd10) begin fails++; $display("FAIL post_vend_coin got %0d want 10", balance); end
  endtask

  task automatic test_valid_ignored_in_vend();
    do_reset();
    restock(3'd0, 4'd1, 8'd5);
    coin(2'b01);
    buttons = 3'd0; select = 1'b1; cyc();
    select = 1'b0; valid = 1'b1; item = 3'd0; count = 4'd7; cost = 8'd99; cyc(); valid = 1'b0;
    tests++; if (status !== 2'b01) begin fails++; $display("FAIL vend0_status got %0d want 1", status); end
    cyc();
    tests++; if (info !== 8'd5) begin fails++; $display("FAIL cost_untouched got %0d want 5", info); end
    coin(2'b01);
    vend(3'd0);
    tests++; if (status !== 2'b11) begin fails++; $display("FAIL stock_untouched got %0d want 3", status); end
  endtask

`ifdef VM_REFUND_EN
  task automatic test_refund();
    do_reset();
    coin(2'b10); coin(2'b01);
    buttons = 3'd1; select = 1'b1; cancel = 1'b1; cyc(); cancel = 1'b0; select = 1'b0;
    tests++; if (change !== 16'd15) begin fails++; $display("FAIL refund_change got %0d want 15", change); end
    tests++; if (balance !== 16'd0) begin fails++; $display("FAIL refund_balance got %0d want 0", balance); end
    tests++; if (status !== 2'b00) begin fails++; $display("FAIL refund_status got %0d want 0", status); end
    cyc(); cyc();
    tests++; if (change !== 16'd0 || status !== 2'b00) begin
      fails++; $display("FAIL refund_after got change %0d status %0d want 0 0", change, status);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_vend_change();
    test_soldout();
    test_nofunds();
    test_saturate();
    test_restock_select();
    test_zero_cost_and_coin_in_vend();
    test_valid_ignored_in_vend();
`ifdef VM_REFUND_EN
    test_refund();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
